// File: rtl/trena_pkg.sv
// trena_pkg: shared definitions for the trena measurement sequencer.
// State codes, ASCII constants and the shared counter width helper.
package trena_pkg;

  typedef logic [3:0] estado_t;

  localparam estado_t ST_INICIAL        = 4'h0;
  localparam estado_t ST_DISPARA        = 4'h1;
  localparam estado_t ST_AGUARDA_MEDIDA = 4'h2;
  localparam estado_t ST_TRANSMITE      = 4'h3;
  localparam estado_t ST_ESPERA_TX      = 4'h4;
  localparam estado_t ST_FIM            = 4'h5;
  localparam estado_t ST_ESPERA_PERIODO = 4'h6;
  localparam estado_t ST_TIMEOUT        = 4'hF;

  localparam logic [2:0] ASCII_DIGITO_PREFIXO = 3'b011;
  localparam logic [6:0] ASCII_HASH           = 7'h23;
  localparam logic [6:0] ASCII_MENOS          = 7'h2D;

  // Width of the shared counter: must hold the larger of the two limits.
  function automatic int largura_contador(input int timeout_ciclos, input int periodo_ciclos);
    int maior;
    maior = (timeout_ciclos > periodo_ciclos) ? timeout_ciclos : periodo_ciclos;
    return $clog2(maior + 1);
  endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m: generic up counter with synchronous clear (clear wins over count).
module contador_m #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_zera,
  input  logic         i_conta,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear has priority; otherwise count when enabled.
  always_ff @(posedge i_clock) begin
    if (i_zera) begin
      r_q <= '0;
    end else if (i_conta) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/trena_seq_serial.sv
// trena_seq_serial: measurement sequencer between the HC-SR04 interface and
// the serial transmitter. Triggers a measurement, latches the BCD result and
// streams it MSB-first as ASCII plus a terminator; single-shot or periodic.
// Optional build macro TRENA_QUADRO_ERRO_EN: after a sensor timeout, send an
// error frame of '-' characters plus the terminator, then pulse pronto.
//
// Handshakes: every control signal here is a one-cycle pulse. sensor_medir and
// tx_partida are issued for exactly one cycle; medida_pronto is accepted only
// in AGUARDA_MEDIDA and tx_pronto only in ESPERA_TX, anything else is ignored.
// tx_pronto is registered before use, so it starts the next character two
// cycles after it arrives.
module trena_seq_serial
  import trena_pkg::*;
#(
  parameter int         N_DIGITOS      = 3,
  parameter logic [6:0] TERMINADOR     = ASCII_HASH,
  parameter int         TIMEOUT_CICLOS = 50000000,
  parameter int         PERIODO_CICLOS = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   medir,
  input  logic                   continuo,
  input  logic [4*N_DIGITOS-1:0] medida_bcd,
  input  logic                   medida_pronto,
  input  logic                   tx_pronto,
  output logic                   sensor_medir,
  output logic                   tx_partida,
  output logic [6:0]             tx_dados,
  output logic                   pronto,
  output logic                   timeout,
  output logic                   ocupado,
  output logic [3:0]             db_estado
);

  localparam int              W_CONT       = largura_contador(TIMEOUT_CICLOS, PERIODO_CICLOS);
  localparam logic [W_CONT-1:0] CONT_TIMEOUT = W_CONT'(TIMEOUT_CICLOS - 1);
  localparam logic [W_CONT-1:0] CONT_PERIODO = W_CONT'(PERIODO_CICLOS - 1);
  localparam logic [3:0]      IDX_FIM      = 4'(N_DIGITOS);

  estado_t                r_estado;
  estado_t                w_prox;
  logic [3:0]             r_idx;
  logic [4*N_DIGITOS-1:0] r_medida;
  logic                   r_quadro_erro;
  logic                   r_tx_pronto;
  logic [W_CONT-1:0]      w_contagem;
  logic                   w_zera;
  logic                   w_conta;
  logic [3:0]             w_digito;
  logic [6:0]             w_caractere;

  // One counter serves both the sensor timeout and the inter-frame period;
  // it is cleared on every entry into a waiting state so it never wraps.
  assign w_zera  = reset || (r_estado == ST_DISPARA) || (r_estado == ST_FIM) ||
                   (r_estado == ST_TIMEOUT);
  assign w_conta = (r_estado == ST_AGUARDA_MEDIDA) || (r_estado == ST_ESPERA_PERIODO);

  contador_m #(.W(W_CONT)) u_contador (
    .i_clock (clock),
    .i_zera  (w_zera),
    .i_conta (w_conta),
    .o_q     (w_contagem)
  );

  // Next-state logic; a measurement arriving on the timeout cycle wins.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_INICIAL:        if (medir) w_prox = ST_DISPARA;
      ST_DISPARA:        w_prox = ST_AGUARDA_MEDIDA;
      ST_AGUARDA_MEDIDA: begin
        if (medida_pronto)                  w_prox = ST_TRANSMITE;
        else if (w_contagem == CONT_TIMEOUT) w_prox = ST_TIMEOUT;
      end
      ST_TRANSMITE:      w_prox = ST_ESPERA_TX;
      ST_ESPERA_TX: begin
        if (r_tx_pronto) w_prox = (r_idx == IDX_FIM) ? ST_FIM : ST_TRANSMITE;
      end
      ST_FIM:            w_prox = continuo ? ST_ESPERA_PERIODO : ST_INICIAL;
`ifdef TRENA_QUADRO_ERRO_EN
      ST_TIMEOUT:        w_prox = ST_TRANSMITE;
`else
      ST_TIMEOUT:        w_prox = continuo ? ST_ESPERA_PERIODO : ST_INICIAL;
`endif
      ST_ESPERA_PERIODO: begin
        if (!continuo)                       w_prox = ST_INICIAL;
        else if (w_contagem == CONT_PERIODO) w_prox = ST_DISPARA;
      end
      default:           w_prox = ST_INICIAL;
    endcase
  end

  // State register and registered tx_pronto (only meaningful in ESPERA_TX).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= ST_INICIAL;
      r_tx_pronto <= 1'b0;
    end else begin
      r_estado    <= w_prox;
      r_tx_pronto <= tx_pronto && (r_estado == ST_ESPERA_TX);
    end
  end

  // Result latch and character index for the frame being sent.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_medida      <= '0;
      r_idx         <= '0;
      r_quadro_erro <= 1'b0;
    end else begin
      if ((r_estado == ST_AGUARDA_MEDIDA) && medida_pronto) begin
        r_medida      <= medida_bcd;
        r_idx         <= '0;
        r_quadro_erro <= 1'b0;
      end
`ifdef TRENA_QUADRO_ERRO_EN
      if (r_estado == ST_TIMEOUT) begin
        r_idx         <= '0;
        r_quadro_erro <= 1'b1;
      end
`endif
      if ((r_estado == ST_ESPERA_TX) && r_tx_pronto && (r_idx != IDX_FIM)) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Character mux: digits MSB-first, then the terminator; zero when idle.
  always_comb begin
    w_digito = '0;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (r_idx == 4'(k)) w_digito = r_medida[4*(N_DIGITOS-1-k) +: 4];
    end
    w_caractere = TERMINADOR;
    if (r_idx < IDX_FIM) begin
      w_caractere = r_quadro_erro ? ASCII_MENOS : {ASCII_DIGITO_PREFIXO, w_digito};
    end
    tx_dados = '0;
    if ((r_estado == ST_TRANSMITE) || (r_estado == ST_ESPERA_TX)) tx_dados = w_caractere;
  end

  assign sensor_medir = (r_estado == ST_DISPARA);
  assign tx_partida   = (r_estado == ST_TRANSMITE);
  assign pronto       = (r_estado == ST_FIM);
  assign timeout      = (r_estado == ST_TIMEOUT);
  assign ocupado      = (r_estado != ST_INICIAL);
  assign db_estado    = r_estado;

endmodule

// File: doc/trena_seq_serial.md
Name: trena_seq_serial

Overview:
- Parametrised measurement sequencer for the digital tape measure (trena).
- Sits between the HC-SR04 interface and the 7O1 serial transmitter, and owns its own FSM, timeout and period counters.
- Triggers a measurement, latches an N-digit BCD result, then streams it MSB-first as ASCII followed by a configurable terminator.
- Supports single-shot and continuous (periodic) modes.

Parameters:
N_DIGITOS, 3, number of BCD digits in medida_bcd (1..8)
TERMINADOR, 7'h23, ASCII code sent after the last digit ("#")
TIMEOUT_CICLOS, 50000000, clock cycles to wait for medida_pronto before aborting
PERIODO_CICLOS, 50000000, idle cycles between frames in continuous mode

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
medir  in  1  start request; sampled only in INICIAL
continuo  in  1  1 = repeat measurements every PERIODO_CICLOS
medida_bcd  in  4*N_DIGITOS  BCD distance from sensor interface; digit N_DIGITOS-1 is most significant
medida_pronto  in  1  1-cycle pulse from sensor interface, result valid
tx_pronto  in  1  1-cycle pulse from transmitter, character finished
sensor_medir  out  1  1-cycle pulse to sensor interface
tx_partida  out  1  1-cycle pulse to transmitter
tx_dados  out  7  ASCII character for transmitter
pronto  out  1  1-cycle pulse, frame complete
timeout  out  1  1-cycle pulse, sensor did not answer
ocupado  out  1  high whenever state != INICIAL
db_estado  out  4  current state code

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset state: FSM goes to INICIAL; all pulse outputs 0, ocupado 0, db_estado 0, tx_dados 0; latch and counters cleared.
- Reset mid-operation: returns to INICIAL next edge; no further tx_partida is issued.
- State codes: INICIAL 0, DISPARA 1, AGUARDA_MEDIDA 2, TRANSMITE 3, ESPERA_TX 4, FIM 5, ESPERA_PERIODO 6, TIMEOUT F.
- INICIAL: medir=1 -> DISPARA.
- DISPARA: sensor_medir=1 for this cycle; clear counter -> AGUARDA_MEDIDA.
  - Latency: medir at t gives sensor_medir at t+1.
- AGUARDA_MEDIDA: counter increments each cycle.
  - medida_pronto=1: latch medida_bcd, idx=0 -> TRANSMITE.
  - Otherwise, counter==TIMEOUT_CICLOS-1 -> TIMEOUT.
  - medida_pronto and the timeout condition in the same cycle: the measurement wins.
- TRANSMITE: tx_partida=1 for one cycle -> ESPERA_TX.
- ESPERA_TX: on tx_pronto:
  - idx==N_DIGITOS -> FIM.
  - Otherwise idx++ -> TRANSMITE.
  - Latency: tx_pronto at m gives the next tx_partida at m+2.
- tx_dados selection (combinational from idx and latch; stable for the whole character):
  - idx<N_DIGITOS: {3'b011, digit[N_DIGITOS-1-idx]}.
  - idx==N_DIGITOS: TERMINADOR.
  - Nibbles >9 are sent unchecked (0x3A..0x3F).
- FIM: pronto=1 for one cycle.
  - continuo=1: clear counter -> ESPERA_PERIODO.
  - Otherwise -> INICIAL.
- TIMEOUT: timeout=1 for one cycle; same continuo branch as FIM.
- ESPERA_PERIODO:
  - continuo=0 -> INICIAL next cycle.
  - Otherwise, counter==PERIODO_CICLOS-1 -> DISPARA.
- One shared counter, width $clog2(max(TIMEOUT_CICLOS, PERIODO_CICLOS)+1); it never wraps because it is cleared on each entry.
- Ignored inputs:
  - medir outside INICIAL.
  - medida_pronto outside AGUARDA_MEDIDA.
  - tx_pronto outside ESPERA_TX.
  - medida_bcd changes after latching do not affect the current frame.

Optional Feature:
- Macro: TRENA_QUADRO_ERRO_EN.
- Defined: TIMEOUT is followed by an error frame of N_DIGITOS '-' (7'h2D) plus TERMINADOR, using the TRANSMITE/ESPERA_TX handshake. The timeout pulse is still asserted in TIMEOUT; pronto is asserted after the error frame.
- Undefined: timeout produces no serial output and no pronto.

Decomposition:
- Package trena_pkg holds:
  - state type and codes;
  - ASCII constants ASCII_DIGITO_PREFIXO=3'b011, ASCII_HASH=7'h23, ASCII_MENOS=7'h2D;
  - a function computing the counter width.
- One sub-module: the existing generic counter contador_m, instantiated once as the shared timeout/period counter. The FSM and output mux stay in this module.

Test Plan (N_DIGITOS=3, TIMEOUT_CICLOS=100, PERIODO_CICLOS=50):
- Single shot: medir pulse, medida_bcd=12'h215, medida_pronto 20 cycles later, tx_pronto 10 cycles after each tx_partida -> tx_dados 0x32, 0x31, 0x35, 0x23; pronto once; back to INICIAL, ocupado 0.
- Timeout: medir, no medida_pronto -> timeout pulse exactly 100 cycles after AGUARDA_MEDIDA entry; no tx_partida; db_estado returns to 0.
- Continuous: continuo=1, medida_bcd=12'h099 -> frame 0x30, 0x39, 0x39, 0x23; next sensor_medir 51 cycles after pronto. Dropping continuo in ESPERA_PERIODO -> INICIAL next cycle.
- Robustness: medir pulses and medida_bcd changed to 12'h777 during transmission -> ignored; frame stays 2,1,5,#.
- Reset during ESPERA_TX: all outputs 0 next cycle; no tx_partida even when tx_pronto arrives afterwards.
- With TRENA_QUADRO_ERRO_EN defined: timeout case -> timeout pulse, then 0x2D, 0x2D, 0x2D, 0x23, then pronto.
